alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 reg_a  input  WIDTH  operand A; sampled on input handshake.
REQ-007 reg_b  input  WIDTH  operand B; sampled on input handshake.
REQ-008 alu_ctrl  input  4  opcode; sampled on input handshake.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result_value  output  WIDTH  registered result.
REQ-012 zero  output  1  high when result_value is all zeros; qualified by out_valid.

Function
REQ-013 Opcodes SHALL be: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 MUL; any other code SHALL produce result 0 as a single-cycle op.
REQ-014 Input handshake SHALL occur on a cycle with in_valid && in_ready; output handshake on out_valid && out_ready.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 IDLE->DONE on handshake of a single-cycle op: result registered, out_valid high at cycle N+1.
REQ-017 IDLE->BUSY on handshake of MUL; BUSY SHALL run radix-2 shift-add for exactly WIDTH cycles, then enter DONE, so out_valid is high at cycle N+1+WIDTH.
REQ-018 DONE->IDLE on output handshake; result_value and zero SHALL remain stable while out_valid && !out_ready.
REQ-019 No new operation is accepted in BUSY or DONE; peak throughput is one single-cycle op per 2 cycles.
REQ-020 ADD/SUB/MUL SHALL be modulo 2^WIDTH (unsigned wrap, no carry/overflow output); MUL returns the low WIDTH bits of the product.
REQ-021 Operand or opcode changes after the input handshake SHALL NOT affect the in-flight result.
REQ-022 in_valid while not IDLE SHALL be ignored; the requester holds it until in_ready.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, result_value 0, out_valid 0, in_ready 1 after release, and clear the iteration counter and partial product.
REQ-024 Reset during BUSY or DONE SHALL discard the operation; no out_valid pulse follows deassertion.

Configuration
REQ-025 Macro ALU_MC_DIV_EN: when defined, opcodes 0110 DIV (unsigned quotient) and 0111 REM (unsigned remainder) SHALL use restoring division, taking WIDTH BUSY cycles with the same latency as MUL.
REQ-026 With ALU_MC_DIV_EN defined, divide by zero SHALL give DIV = all ones and REM = reg_a, with unchanged latency.
REQ-027 Without ALU_MC_DIV_EN, 0110/0111 SHALL behave as undefined opcodes (result 0, single cycle) and no divider logic is synthesised.

Verification
REQ-028 ADD a=7, b=5 accepted cycle N -> out_valid at N+1, result 12, zero 0; SUB a=0, b=1 -> 0xFFFFFFFF.
REQ-029 MUL 123*456 -> result 56088 with out_valid exactly at N+33 (WIDTH=32); MUL 0x10000*0x10000 -> result 0, zero 1.
REQ-030 Backpressure: out_ready low 5 cycles after ADD result -> result stable, in_ready 0, second in_valid ignored until handshake, then accepted next IDLE cycle.
REQ-031 Reset mid-MUL: rst_n low at BUSY cycle 10 -> out_valid 0 immediately, in_ready 1 after release, no stale result afterwards.
REQ-032 With ALU_MC_DIV_EN: DIV 100/7 -> 14 and REM 100/7 -> 2, each at N+33; DIV 9/0 -> 0xFFFFFFFF and REM 9/0 -> 9; without the macro, opcode 0110 -> 0 at N+1.
REQ-033 Opcode 1111 -> result 0, zero 1, out_valid at N+1.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for alu_mc.
// master drives operands/opcode and out_ready; slave (the ALU) drives
// in_ready, out_valid, result_value and zero.
interface alu_mc_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic [3:0]       alu_ctrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result_value;
   logic             zero;

   modport master (
      output in_valid, reg_a, reg_b, alu_ctrl, out_ready,
      input  in_ready, out_valid, result_value, zero
   );

   modport slave (
      input  in_valid, reg_a, reg_b, alu_ctrl, out_ready,
      output in_ready, out_valid, result_value, zero
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes.
// ADD/SUB/AND/OR and unknown opcodes complete in one cycle; MUL runs a
// radix-2 shift-add over WIDTH cycles. Define ALU_MC_DIV_EN to add
// restoring DIV (0110) and REM (0111) with the same latency as MUL.
module alu_mc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_mc_if.slave     bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
`ifdef ALU_MC_DIV_EN
   localparam logic [3:0] OP_DIV = 4'b0110;
   localparam logic [3:0] OP_REM = 4'b0111;
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] acc;   // partial product / partial remainder
   logic [WIDTH-1:0] opa;   // multiplier (shifts right) / dividend-quotient
   logic [WIDTH-1:0] opb;   // multiplicand (shifts left) / divisor
   logic [CW-1:0]    cnt;
   logic             long_op;
   logic             last_iter;
   logic [WIDTH-1:0] single_res;
   logic [WIDTH-1:0] mul_nxt;
   logic [WIDTH-1:0] step_res;
`ifdef ALU_MC_DIV_EN
   logic             div_mode;
   logic             rem_sel;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quot_nxt;
`endif

   // Opcode decode and single-cycle results
   always_comb begin
      single_res = '0;
      long_op    = 1'b0;
      case (bus.alu_ctrl)
         OP_ADD:  single_res = bus.reg_a + bus.reg_b;
         OP_SUB:  single_res = bus.reg_a - bus.reg_b;
         OP_AND:  single_res = bus.reg_a & bus.reg_b;
         OP_OR:   single_res = bus.reg_a | bus.reg_b;
         OP_MUL:  long_op    = 1'b1;
`ifdef ALU_MC_DIV_EN
         OP_DIV,
         OP_REM:  long_op    = 1'b1;
`endif
         default: single_res = '0;
      endcase
   end

   // One iteration of the shift-add multiplier / restoring divider
   always_comb begin
      last_iter = (cnt == CW'(WIDTH - 1));
      mul_nxt   = acc + (opa[0] ? opb : '0);
`ifdef ALU_MC_DIV_EN
      // Divide by zero falls out naturally: every trial subtract succeeds,
      // so the quotient is all ones and the remainder collects reg_a.
      rem_sh   = {acc, opa[WIDTH-1]};
      diff     = rem_sh - {1'b0, opb};
      rem_nxt  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quot_nxt = {opa[WIDTH-2:0], ~diff[WIDTH]};
      step_res = div_mode ? (rem_sel ? rem_nxt : quot_nxt) : mul_nxt;
`else
      step_res = mul_nxt;
`endif
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_nxt        = state;
      bus.in_ready     = (state == IDLE);
      bus.out_valid    = (state == DONE);
      bus.result_value = result;
      bus.zero         = (state == DONE) && (result == '0);
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = long_op ? BUSY : DONE;
         BUSY:    if (last_iter)    state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, iterative datapath and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result   <= '0;
         acc      <= '0;
         opa      <= '0;
         opb      <= '0;
         cnt      <= '0;
`ifdef ALU_MC_DIV_EN
         div_mode <= 1'b0;
         rem_sel  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (long_op) begin
                     acc      <= '0;
                     opa      <= bus.reg_a;
                     opb      <= bus.reg_b;
                     cnt      <= '0;
`ifdef ALU_MC_DIV_EN
                     div_mode <= (bus.alu_ctrl == OP_DIV) || (bus.alu_ctrl == OP_REM);
                     rem_sel  <= (bus.alu_ctrl == OP_REM);
`endif
                  end else begin
                     result <= single_res;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt + CW'(1);
`ifdef ALU_MC_DIV_EN
               if (div_mode) begin
                  acc <= rem_nxt;
                  opa <= quot_nxt;
               end else
`endif
               begin
                  acc <= mul_nxt;
                  opa <= opa >> 1;
                  opb <= opb << 1;
               end
               if (last_iter) result <= step_res;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH=32). Stimulus pushes the
// expected result and latency; a negedge monitor pops and compares.
module tb_alu_mc;
   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] res;
      int           lat;
   } exp_t;

   logic clk;
   logic rst_n;
   alu_mc_if #(.WIDTH(W)) bus ();

   alu_mc #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   bp_hold = 1'b0;
   bit   have = 1'b0;
   exp_t cur;
   int   t = 0;
   int   hs_t = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0d)", name, act, exp, t);
      end
   endtask

   // Reference model straight from the opcode table
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.lat = 1;
      case (op)
         4'b0001: e.res = a + b;
         4'b0010: e.res = a - b;
         4'b0011: e.res = a & b;
         4'b0100: e.res = a | b;
         4'b0101: begin e.res = a * b; e.lat = W + 1; end
`ifdef ALU_MC_DIV_EN
         4'b0110: begin e.res = (b == 0) ? {W{1'b1}} : a / b; e.lat = W + 1; end
         4'b0111: begin e.res = (b == 0) ? a : a % b;         e.lat = W + 1; end
`endif
         default: e.res = '0;
      endcase
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_opnd();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   // Out_ready: random, or held low when bp_hold is set
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bus.out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops on first out_valid cycle, checks value while held
   always @(negedge clk) begin
      t++;
      if (!rst_n) begin
         have = 1'b0;
      end else begin
         if (bus.out_valid) begin
            if (!have) begin
               if (q.size() == 0) begin
                  chk("unexpected_out_valid", 1, 0);
               end else begin
                  cur  = q.pop_front();
                  have = 1'b1;
                  chk("latency", 64'(t - hs_t), 64'(cur.lat));
               end
            end
            if (have) begin
               chk("result", bus.result_value, cur.res);
               chk("zero", bus.zero, (cur.res == '0));
               if (bus.out_ready) have = 1'b0;
            end
         end
         if (bus.in_valid && bus.in_ready) hs_t = t;
      end
   end

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      bit   rdy;
      int   n;
      e = model(op, a, b);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.reg_a    = a;
      bus.reg_b    = b;
      bus.alu_ctrl = op;
      n = 0;
      do begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 500);
      if (!rdy) chk("accept_timeout", 0, 1);
      else      q.push_back(e);
      bus.in_valid = 1'b0;
      // Disturb inputs after acceptance; the in-flight op must not notice.
      bus.reg_a    = W'($urandom);
      bus.reg_b    = W'($urandom);
      bus.alu_ctrl = 4'($urandom);
   endtask

   initial begin
      int n;
      int seen;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.reg_a    = '0;
      bus.reg_b    = '0;
      bus.alu_ctrl = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result", bus.result_value, 0);
      chk("rst_zero", bus.zero, 0);

      // Directed cases
      issue(4'b0001, 7, 5);
      issue(4'b0010, 0, 1);
      issue(4'b0101, 123, 456);
      issue(4'b0101, 32'h10000, 32'h10000);
      issue(4'b1111, 32'h1234, 32'h5678);
      issue(4'b0110, 100, 7);
      issue(4'b0111, 100, 7);
      issue(4'b0110, 9, 0);
      issue(4'b0111, 9, 0);
      issue(4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF);

      // Backpressure: hold out_ready low while a second request waits
      issue(4'b0001, 32'h40, 32'h2);
      bp_hold = 1'b1;
      fork
         issue(4'b0100, 32'hF0, 32'h0F);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("bp_in_ready", bus.in_ready, 0);
               chk("bp_out_valid", bus.out_valid, 1);
            end
            bp_hold = 1'b0;
         end
      join

      // Reset during MUL
      issue(4'b0101, 3, 5);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("rst_mid_out_valid", bus.out_valid, 0);
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 1);
      chk("post_rst_result", bus.result_value, 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("post_rst_no_valid", seen, 0);

      // Randomized operations
      repeat (40) issue(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());

      n = 0;
      while ((q.size() != 0 || have) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", (q.size() != 0 || have), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
